// File: rtl/current_limit_pkg.sv
// Shared types and width helpers for the current-limit arbiter.
package current_limit_pkg;

    typedef enum logic [1:0] {IDLE, HELD, FREE} ch_state_t;

    localparam int MAX_CH = 16;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int age_w(input int slice);
        return $clog2(slice + 1);
    endfunction

    function automatic logic [4:0] popcount(input logic [MAX_CH-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: grants up to 'slots' eligible channels starting at 'start'.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 3
) (
    input  logic [N-1:0]     elig,
    input  logic [PTR_W-1:0] start,
    input  logic [CNT_W-1:0] slots,
    output logic [N-1:0]     pick,
    output logic [PTR_W-1:0] next_ptr
);

    always_comb begin : scan
        logic [CNT_W-1:0] taken;
        pick     = '0;
        next_ptr = start;
        taken    = '0;
        for (int k = 0; k < N; k++) begin
            logic [PTR_W:0]   sum;
            logic [PTR_W-1:0] idx;
            sum = {1'b0, start} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            idx = sum[PTR_W-1:0];
            if (elig[idx] && (taken < slots)) begin
                pick[idx] = 1'b1;
                taken     = taken + CNT_W'(1);
                next_ptr  = (idx == PTR_W'(N - 1)) ? '0 : idx + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/current_limit_arbiter.sv
// Shares a supply-current budget: at most MAX_ON concurrent grants, round-robin,
// minimum on-time HOLD, pre-emption of grants aged SLICE while others starve.
module current_limit_arbiter
    import current_limit_pkg::*;
#(
    parameter int N      = 4,
    parameter int MAX_ON = 2,
    parameter int HOLD   = 4,
    parameter int SLICE  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    output logic [N-1:0]           gnt,
    output logic [$clog2(N+1)-1:0] on_cnt,
    output logic                   starve
);

    localparam int CNT_W = cnt_w(N);
    localparam int AGE_W = age_w(SLICE);
    localparam int PTR_W = $clog2(N);
    localparam logic [AGE_W-1:0] HOLD_A   = AGE_W'(HOLD);
    localparam logic [AGE_W-1:0] SLICE_A  = AGE_W'(SLICE);
    localparam logic [CNT_W-1:0] MAX_ON_C = CNT_W'(MAX_ON);

    generate
        if (N < 2 || N > MAX_CH || MAX_ON < 1 || MAX_ON > N || HOLD < 1 || SLICE < HOLD) begin : g_bad_params
            $error("current_limit_arbiter: illegal parameters N=%0d MAX_ON=%0d HOLD=%0d SLICE=%0d",
                   N, MAX_ON, HOLD, SLICE);
        end
    endgenerate

    function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
        return (a >= SLICE_A) ? SLICE_A : a + AGE_W'(1);
    endfunction

    function automatic ch_state_t state_of(input logic [AGE_W-1:0] a);
        return (a >= HOLD_A) ? FREE : HELD;
    endfunction

    function automatic logic [CNT_W-1:0] count(input logic [N-1:0] v);
        return CNT_W'(popcount(MAX_CH'(v)));
    endfunction

    ch_state_t        state [N];
    logic [AGE_W-1:0] age   [N];
    logic [N-1:0]     cool, free_mask, sat_mask, norm_rel, pre_cand, pre_rel, rel;
    logic [N-1:0]     waiting, pick, gnt_next;
    logic [PTR_W-1:0] rr_ptr, next_ptr;
    logic [CNT_W-1:0] remain_pre, slots;
    logic             starving;

    generate
        for (genvar i = 0; i < N; i++) begin : g_ch
            ch_state_t        st_q;
            logic [AGE_W-1:0] age_q;
            logic             gnt_q, cool_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    st_q   <= IDLE;
                    age_q  <= '0;
                    gnt_q  <= 1'b0;
                    cool_q <= 1'b0;
                end else begin
                    cool_q <= rel[i];
                    if (st_q == IDLE) begin
                        if (pick[i]) begin
                            st_q  <= state_of(AGE_W'(1));
                            age_q <= AGE_W'(1);
                            gnt_q <= 1'b1;
                        end
                    end else if (rel[i]) begin
                        st_q  <= IDLE;
                        age_q <= '0;
                        gnt_q <= 1'b0;
                    end else begin
                        st_q  <= state_of(age_sat_inc(age_q));
                        age_q <= age_sat_inc(age_q);
                    end
                end
            end

            assign state[i]     = st_q;
            assign age[i]       = age_q;
            assign gnt[i]       = gnt_q;
            assign cool[i]      = cool_q;
            assign free_mask[i] = (st_q == FREE);
            assign sat_mask[i]  = (age_q == SLICE_A);
        end
    endgenerate

    // Release first: voluntary drops, then at most one pre-emption (lowest saturated index).
    assign norm_rel   = free_mask & ~req;
    assign waiting    = req & ~gnt & ~cool;
    assign remain_pre = count(gnt & ~norm_rel);
    assign starving   = (|waiting) && (remain_pre == MAX_ON_C);
    assign pre_cand   = free_mask & req & sat_mask & {N{starving}};
    assign pre_rel    = pre_cand & (~pre_cand + N'(1));
    assign rel        = norm_rel | pre_rel;
    assign slots      = MAX_ON_C - count(gnt & ~rel);

    rr_pick #(
        .N     (N),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_rr_pick (
        .elig     (waiting),
        .start    (rr_ptr),
        .slots    (slots),
        .pick     (pick),
        .next_ptr (next_ptr)
    );

    assign gnt_next = (gnt & ~rel) | pick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_cnt <= '0;
            starve <= 1'b0;
            rr_ptr <= '0;
        end else begin
            on_cnt <= count(gnt_next);
            starve <= (|(req & ~gnt_next)) && (count(gnt_next) == MAX_ON_C);
            rr_ptr <= next_ptr;
        end
    end

    a_count_ok : assert property (@(posedge clk) disable iff (rst)
        (count(gnt) == on_cnt) && (on_cnt <= MAX_ON_C));

    a_no_held_release : assert property (@(posedge clk) disable iff (rst)
        ((rel & ~free_mask) == '0));

endmodule

// File: tb/tb_current_limit_arbiter.sv
// Directed and model-checked bench for current_limit_arbiter (N=4, MAX_ON=2, HOLD=4, SLICE=16).
module tb_current_limit_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [2:0] on_cnt;
    logic       starve;

    int checks;
    int errors;

    current_limit_arbiter #(
        .N      (4),
        .MAX_ON (2),
        .HOLD   (4),
        .SLICE  (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .on_cnt (on_cnt),
        .starve (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference model state
    logic [3:0] m_gnt;
    logic [3:0] m_cool;
    int         m_age [4];
    int         m_ptr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_gnt  = 4'b0000;
        m_cool = 4'b0000;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
        m_ptr = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] rel;
        logic [3:0] ng;
        int         remain;
        int         slots;
        int         last;
        bit         wait_any;
        bit         found;
        rel = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (m_gnt[i] && m_age[i] >= 4 && !r[i]) rel[i] = 1'b1;
        remain   = 0;
        wait_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_gnt[i] && !rel[i]) remain++;
            if (r[i] && !m_gnt[i] && !m_cool[i]) wait_any = 1'b1;
        end
        if (wait_any && remain == 2) begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && m_gnt[i] && r[i] && m_age[i] == 16) begin
                    rel[i] = 1'b1;
                    found  = 1'b1;
                    remain--;
                end
            end
        end
        slots = 2 - remain;
        ng    = m_gnt & ~rel;
        last  = -1;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (slots > 0 && r[c] && !m_gnt[c] && !m_cool[c]) begin
                ng[c] = 1'b1;
                slots--;
                last = c;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (ng[i] && m_gnt[i]) m_age[i] = (m_age[i] >= 16) ? 16 : m_age[i] + 1;
            else if (ng[i])        m_age[i] = 1;
            else                   m_age[i] = 0;
        end
        m_cool = rel;
        m_gnt  = ng;
        if (last >= 0) m_ptr = (last + 1) % 4;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 4'b0000 || on_cnt !== 3'd0 || starve !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got gnt=%b on_cnt=%0d starve=%b exp 0000/0/0", gnt, on_cnt, starve);
        end
        req = 4'b1111;
        repeat (3) step();
        checks++;
        if (gnt !== 4'b0011) begin
            errors++;
            $display("FAIL reset_pregrant got gnt=%b exp 0011", gnt);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || on_cnt !== 3'd0 || starve !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got gnt=%b on_cnt=%0d starve=%b exp 0000/0/0", gnt, on_cnt, starve);
        end
        step();
        checks++;
        if (gnt !== 4'b0000 || on_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_held got gnt=%b on_cnt=%0d exp 0000/0", gnt, on_cnt);
        end
        rst = 1'b0;
        req = 4'b0000;
    endtask

    task automatic test_preempt();
        do_reset();
        req = 4'b1111;
        step();
        checks++;
        if (gnt !== 4'b0011 || on_cnt !== 3'd2 || starve !== 1'b1) begin
            errors++;
            $display("FAIL preempt_first got gnt=%b on_cnt=%0d starve=%b exp 0011/2/1", gnt, on_cnt, starve);
        end
        repeat (15) step();
        checks++;
        if (gnt !== 4'b0011) begin
            errors++;
            $display("FAIL preempt_hold16 got gnt=%b exp 0011", gnt);
        end
        step();
        checks++;
        if (gnt !== 4'b0110 || on_cnt !== 3'd2 || starve !== 1'b1) begin
            errors++;
            $display("FAIL preempt_ch0 got gnt=%b on_cnt=%0d starve=%b exp 0110/2/1", gnt, on_cnt, starve);
        end
        step();
        checks++;
        if (gnt !== 4'b1100 || on_cnt !== 3'd2) begin
            errors++;
            $display("FAIL preempt_ch1 got gnt=%b on_cnt=%0d exp 1100/2", gnt, on_cnt);
        end
        step();
        checks++;
        if (gnt !== 4'b1100) begin
            errors++;
            $display("FAIL preempt_settle got gnt=%b exp 1100", gnt);
        end
    endtask

    task automatic test_hold_pulse();
        do_reset();
        req = 4'b0001;
        step();
        checks++;
        if (gnt !== 4'b0001 || on_cnt !== 3'd1 || starve !== 1'b0) begin
            errors++;
            $display("FAIL pulse_grant got gnt=%b on_cnt=%0d starve=%b exp 0001/1/0", gnt, on_cnt, starve);
        end
        req = 4'b0000;
        repeat (3) step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL pulse_held got gnt=%b exp 0001", gnt);
        end
        step();
        checks++;
        if (gnt !== 4'b0000 || on_cnt !== 3'd0) begin
            errors++;
            $display("FAIL pulse_release got gnt=%b on_cnt=%0d exp 0000/0", gnt, on_cnt);
        end
        req = 4'b0001;
        step();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL pulse_cooldown got gnt=%b exp 0000", gnt);
        end
        step();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL pulse_regrant got gnt=%b exp 0001", gnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b1100;
        step();
        checks++;
        if (gnt !== 4'b1100 || on_cnt !== 3'd2 || starve !== 1'b0) begin
            errors++;
            $display("FAIL b2b_setup got gnt=%b on_cnt=%0d starve=%b exp 1100/2/0", gnt, on_cnt, starve);
        end
        repeat (3) step();
        req = 4'b0110;
        step();
        checks++;
        if (gnt !== 4'b0110 || on_cnt !== 3'd2 || starve !== 1'b0) begin
            errors++;
            $display("FAIL b2b_swap got gnt=%b on_cnt=%0d starve=%b exp 0110/2/0", gnt, on_cnt, starve);
        end
    endtask

    task automatic test_fairness();
        int cnt [4];
        int mn;
        int mx;
        int bad;
        do_reset();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        bad = 0;
        req = 4'b1111;
        for (int c = 0; c < 1000; c++) begin
            step();
            for (int i = 0; i < 4; i++) cnt[i] += int'(gnt[i]);
            if (starve && on_cnt != 3'd2) bad++;
        end
        mn = cnt[0];
        mx = cnt[0];
        for (int i = 1; i < 4; i++) begin
            if (cnt[i] < mn) mn = cnt[i];
            if (cnt[i] > mx) mx = cnt[i];
        end
        checks++;
        if (mx - mn > 17 || mn == 0) begin
            errors++;
            $display("FAIL fairness_spread got max=%0d min=%0d exp spread<=17", mx, mn);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fairness_starve got %0d cycles starve without full, exp 0", bad);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        int         run [4];
        logic [2:0] exp_cnt;
        logic       exp_starve;
        do_reset();
        model_reset();
        r = 4'b0000;
        for (int i = 0; i < 4; i++) run[i] = 0;
        for (int c = 0; c < 10000 && errors < 20; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            req = r;
            step();
            model_step(r);
            exp_cnt    = 3'($countones(m_gnt));
            exp_starve = (|(r & ~m_gnt)) && (exp_cnt == 3'd2);
            checks++;
            if (gnt !== m_gnt || on_cnt !== exp_cnt || starve !== exp_starve) begin
                errors++;
                $display("FAIL random_model cycle %0d got gnt=%b on_cnt=%0d starve=%b exp %b/%0d/%b",
                         c, gnt, on_cnt, starve, m_gnt, exp_cnt, exp_starve);
            end
            checks++;
            if (3'($countones(gnt)) !== on_cnt || on_cnt > 3'd2) begin
                errors++;
                $display("FAIL random_invariant cycle %0d got gnt=%b on_cnt=%0d", c, gnt, on_cnt);
            end
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) begin
                    run[i]++;
                end else begin
                    if (run[i] > 0) begin
                        checks++;
                        if (run[i] < 4) begin
                            errors++;
                            $display("FAIL random_hold ch%0d got on-time %0d exp >=4", i, run[i]);
                        end
                    end
                    run[i] = 0;
                end
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        test_reset();
        test_preempt();
        test_hold_pulse();
        test_back_to_back();
        test_fairness();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
